// File: rtl/mac_vec_sat.sv
// Pipelined signed multiply-accumulate with saturation.
// Emits one dot-product per last-delimited vector.
module mac_vec_sat #(
  parameter int IN_W        = 14,
  parameter int ACC_W       = 28,
  parameter int MULT_STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  a,
  input  logic [IN_W-1:0]  b,
  input  logic             valid_in,
  input  logic             last_in,
  output logic [ACC_W-1:0] f,
  output logic             valid_out,
  output logic             sat_out
);

  localparam int PW = 2 * IN_W;

  if (IN_W < 2) begin : g_chk_in
    $error("mac_vec_sat: IN_W must be >= 2");
  end
  if (ACC_W < PW) begin : g_chk_acc
    $error("mac_vec_sat: ACC_W must be >= 2*IN_W");
  end
  if (MULT_STAGES < 1) begin : g_chk_ms
    $error("mac_vec_sat: MULT_STAGES must be >= 1");
  end

  localparam logic [ACC_W-1:0] MAXV = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] MINV = {1'b1, {(ACC_W-1){1'b0}}};

  logic [IN_W-1:0] a_q, b_q;
  logic            vin_q, lin_q;

  logic signed [PW-1:0] ax, bx, prod_d;
  logic signed [PW-1:0] p_q [MULT_STAGES];
  logic [MULT_STAGES-1:0] pv_q, pl_q;

  logic signed [ACC_W-1:0] pext;
  logic [ACC_W-1:0] sum, acc_q, acc_d;
  logic sat_q, sat_d, first_q, first_d;
  logic vout_q, vout_d, ovf, pv, pl;

  // Input capture; last without valid is dropped here.
  always_ff @(posedge clk) begin
    if (reset) begin
      vin_q <= 1'b0;
      lin_q <= 1'b0;
    end else begin
      vin_q <= valid_in;
      lin_q <= valid_in & last_in;
    end
  end

  // Operand data needs no reset; it is qualified by vin_q.
  always_ff @(posedge clk) begin
    a_q <= a;
    b_q <= b;
  end

  assign ax     = PW'($signed(a_q));
  assign bx     = PW'($signed(b_q));
  assign prod_d = ax * bx;

  // Valid/last shift alongside the product pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      pv_q <= '0;
      pl_q <= '0;
    end else begin
      pv_q[0] <= vin_q;
      pl_q[0] <= lin_q;
      for (int i = 1; i < MULT_STAGES; i++) begin
        pv_q[i] <= pv_q[i-1];
        pl_q[i] <= pl_q[i-1];
      end
    end
  end

  // Product data pipeline.
  always_ff @(posedge clk) begin
    p_q[0] <= prod_d;
    for (int i = 1; i < MULT_STAGES; i++) begin
      p_q[i] <= p_q[i-1];
    end
  end

  assign pv   = pv_q[MULT_STAGES-1];
  assign pl   = pl_q[MULT_STAGES-1];
  assign pext = ACC_W'(p_q[MULT_STAGES-1]);
  assign sum  = acc_q + pext;
  assign ovf  = (acc_q[ACC_W-1] == pext[ACC_W-1]) &&
                (sum[ACC_W-1] != acc_q[ACC_W-1]);

  // Load on first product, else saturating add with sticky flag.
  always_comb begin
    acc_d   = acc_q;
    sat_d   = sat_q;
    first_d = first_q;
    vout_d  = 1'b0;
    if (pv) begin
      if (first_q) begin
        acc_d = pext;
        sat_d = 1'b0;
      end else if (ovf) begin
        acc_d = acc_q[ACC_W-1] ? MINV : MAXV;
        sat_d = 1'b1;
      end else begin
        acc_d = sum;
      end
      first_d = pl;
      vout_d  = pl;
    end
  end

  // Accumulator state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q   <= '0;
      sat_q   <= 1'b0;
      first_q <= 1'b1;
      vout_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      sat_q   <= sat_d;
      first_q <= first_d;
      vout_q  <= vout_d;
    end
  end

  assign f         = acc_q;
  assign valid_out = vout_q;
  assign sat_out   = sat_q;

endmodule

// File: doc/mac_vec_sat.md
Name: mac_vec_sat

Overview:
Parametrised, fully pipelined signed multiply-accumulate engine for dot-product (neuron) evaluation in the NN accelerator datapath. It takes one operand pair per cycle, multiplies it through an internal pipeline of configurable depth, and accumulates with saturation. It emits one result per vector, delimited by last_in. Vectors may follow each other back-to-back with no bubble, so the block can be tiled as a PE inside layer-level arrays.

Parameters:
IN_W, 14, signed operand width of a and b (>= 2)
ACC_W, 28, signed accumulator and result width; must be >= 2*IN_W (elaboration error otherwise)
MULT_STAGES, 4, number of register stages inside the multiplier (>= 1)

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
a  input  IN_W  signed operand A, sampled when valid_in=1
b  input  IN_W  signed operand B, sampled when valid_in=1
valid_in  input  1  operand pair valid this cycle; there is no backpressure and the block always accepts
last_in  input  1  qualified by valid_in; marks the final pair of the current vector
f  output  ACC_W  signed saturated dot-product; meaningful only while valid_out=1
valid_out  output  1  one-cycle pulse per completed vector
sat_out  output  1  qualified by valid_out; 1 if any saturation occurred while accumulating that vector

Behaviour:
- Reset is clk, synchronous, active-high. It sets f=0, valid_out=0, sat_out=0, clears every pipeline valid/last bit and the accumulator, and sets first-of-vector state to 1.
- Reset mid-vector discards all in-flight products. The first valid pair after reset deasserts starts a fresh vector.
- Pipeline stages:
  - Input register: at edge k, a, b, valid_in and last_in are captured; pairs with valid_in=0 are captured as bubbles.
  - MULT_STAGES register stages compute the exact signed 2*IN_W-bit product. Valid and last travel alongside the data.
  - Accumulate stage at edge k+MULT_STAGES+1.
- Latency: a last pair presented in cycle k gives valid_out=1 in cycle k+MULT_STAGES+2. With defaults, inputs in cycle 0 give the result in cycle 6.
- Accumulate rule when a valid product p arrives (sign-extended to ACC_W):
  - If it is the first of its vector, acc <= p and the sticky sat flag <= 0.
  - Otherwise acc <= sat(acc + p) and the sticky sat flag |= overflow.
  - Overflow means both operands have the same sign and the sum's sign differs. The result then clamps to 2^(ACC_W-1)-1 if acc >= 0, else to -2^(ACC_W-1).
  - Once saturated, accumulation continues from the clamped value and may recover toward the in-range region.
- Bubbles (valid_in=0) do not touch acc or the flag. Gaps of any length inside a vector are legal.
- When the arriving product carries last=1:
  - acc takes the final value, visible on f.
  - valid_out=1 for exactly one cycle, and sat_out holds that vector's sticky flag.
  - First-of-vector state is set, so the next valid product loads instead of adding.
- Back-to-back vectors: a last pair in cycle k followed by the first pair of the next vector in cycle k+1 is legal. f is correct during the valid_out cycle and is overwritten by the new vector's first product on the following edge.
- A single-element vector (valid_in=1 and last_in=1 in one cycle) gives f=a*b.
- last_in with valid_in=0 is ignored.
- Outside valid_out cycles, f shows the running accumulator and sat_out shows the running flag. Consumers must not rely on them.
- valid_out is never asserted during reset or for a vector whose pairs straddled a reset.

Test Plan:
- Default params. Reset, then one pair a=3, b=-5, valid_in=1, last_in=1 in cycle 0 -> valid_out=1 only in cycle 6, f=-15, sat_out=0.
- Vector (1,2),(3,4),(5,6) with last on the third pair and a 2-cycle bubble after the first pair -> single valid_out pulse, f=44, sat_out=0; no valid_out during the bubbles.
- Positive saturation: a=b=-8192 twice, last on the second -> f=134217727, sat_out=1. The next vector (2,2,last) -> f=4, sat_out=0, proving the flag clears.
- Negative saturation: a=-8192, b=8191 three times, last on the third -> f=-134217728, sat_out=1.
- Back-to-back: vector {(10,10) last} then vector {(7,7),(1,1) last} in consecutive cycles -> valid_out in cycles 6 and 8 with f=100 and f=50 respectively.
- Reset asserted in cycle 3 of a 4-pair vector, then vector (2,3,last) presented after release -> exactly one valid_out, f=6; no pulse for the aborted vector. Repeat with MULT_STAGES=1, IN_W=8, ACC_W=20 and check latency = 3 cycles.
